// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the VGA capture path: FSM states, RGB565
// field widths and CRC-16-CCITT parameters with a one-word update helper.
package vga_capture_pkg;
    localparam int RED_W = 5;
    localparam int GRN_W = 6;
    localparam int BLU_W = 5;
    localparam int PIX_W = RED_W + GRN_W + BLU_W;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN
    } cap_state_e;

    // MSB-first CRC-16-CCITT over one 16-bit word
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? CRC_POLY : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/vga_capture_if.sv
// Video input (syncs + RGB565) and arbiter write port of the capture block.
interface vga_capture_if;
    import vga_capture_pkg::*;

    logic             vid_hsync;
    logic             vid_vsync;
    logic [RED_W-1:0] vid_red;
    logic [GRN_W-1:0] vid_green;
    logic [BLU_W-1:0] vid_blue;
    logic             wr_en;
    logic             data_en;
    logic [PIX_W-1:0] dout;

    modport master (output vid_hsync, vid_vsync, vid_red, vid_green, vid_blue, wr_en,
                    input  data_en, dout);
    modport slave  (input  vid_hsync, vid_vsync, vid_red, vid_green, vid_blue, wr_en,
                    output data_en, dout);
endinterface

// File: rtl/vga_capture_fifo.sv
// Single-clock elastic FIFO, 2^AW x DW, with a registered read port:
// rd_valid/rd_data appear the cycle after an accepted read.
module vga_capture_fifo #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    output logic          full,
    output logic          empty,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          wr, rd;

    assign full  = cnt[AW];
    assign empty = (cnt == '0);
    assign rd    = rd_req & ~empty;
    // a pop in the same cycle frees the slot, so a push at full still lands
    assign wr    = wr_req & (~full | rd);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr];
            end
            rd_valid <= rd;
            case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/vga_capture.sv
// VGA-timed RGB565 capture into the arbiter write port, one frame per start_i.
// Optional frame CRC-16-CCITT: define VGA_CAPTURE_CRC_EN.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_START  = 296,
    parameter int H_ACTIVE = 1024,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 768,
    parameter bit SYNC_POL = 1'b0,
    parameter int FIFO_AW  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    vga_capture_if.slave vif,
    output logic         frame_done,
    output logic         overflow,
    output logic         short_frame,
    output logic [19:0]  word_cnt,
    output logic [15:0]  frame_crc
);
    localparam logic [11:0] H_LO     = 12'(H_START);
    localparam logic [11:0] H_HI     = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] V_LO     = 12'(V_START);
    localparam logic [11:0] V_HI     = 12'(V_START + V_ACTIVE);
    localparam logic [19:0] PIX_LAST = 20'(H_ACTIVE * V_ACTIVE - 1);

    logic             s1_hs, s1_vs, s2_hs, s2_vs;
    logic [PIX_W-1:0] s1_pix;
    logic             hs_edge, vs_edge, active;
    logic [10:0]      hcnt, vcnt, cur_h, cur_v;
    logic [19:0]      pix_cnt;
    cap_state_e       state, state_nx;
    logic             arm, cap, short_set, done_nx;
    logic             fifo_full, fifo_empty;

    // syncs reset to their idle level so reset release is not seen as an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hs  <= ~SYNC_POL;
            s1_vs  <= ~SYNC_POL;
            s2_hs  <= ~SYNC_POL;
            s2_vs  <= ~SYNC_POL;
            s1_pix <= '0;
        end else begin
            s1_hs  <= vif.vid_hsync;
            s1_vs  <= vif.vid_vsync;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s1_pix <= {vif.vid_red, vif.vid_green, vif.vid_blue};
        end
    end

    assign hs_edge = (s1_hs == SYNC_POL) && (s2_hs != SYNC_POL);
    assign vs_edge = (s1_vs == SYNC_POL) && (s2_vs != SYNC_POL);

    // cur_h/cur_v are the coordinates of the pixel now in S1 (sync-edge sample = 0)
    assign cur_h  = hs_edge ? '0 : ((&hcnt) ? hcnt : hcnt + 11'd1);
    assign cur_v  = vs_edge ? '0 : ((hs_edge && !(&vcnt)) ? vcnt + 11'd1 : vcnt);
    assign active = ({1'b0, cur_h} >= H_LO) && ({1'b0, cur_h} < H_HI) &&
                    ({1'b0, cur_v} >= V_LO) && ({1'b0, cur_v} < V_HI);

    always_comb begin
        state_nx  = state;
        arm       = 1'b0;
        cap       = 1'b0;
        short_set = 1'b0;
        done_nx   = 1'b0;
        case (state)
            ST_IDLE:    if (start_i) begin
                            state_nx = ST_ARMED;
                            arm      = 1'b1;
                        end
            ST_ARMED:   if (vs_edge) begin
                            state_nx = ST_CAPTURE;
                            cap      = active;
                        end
            ST_CAPTURE: if (vs_edge) begin
                            state_nx  = ST_DRAIN;
                            short_set = 1'b1;
                        end else begin
                            cap = active;
                        end
            ST_DRAIN:   if (fifo_empty) begin
                            state_nx = ST_IDLE;
                            done_nx  = 1'b1;
                        end
            default:    state_nx = ST_IDLE;
        endcase
        if (cap && pix_cnt == PIX_LAST) state_nx = ST_DRAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            pix_cnt     <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            word_cnt    <= '0;
        end else begin
            state      <= state_nx;
            hcnt       <= cur_h;
            vcnt       <= cur_v;
            frame_done <= done_nx;
            if (arm) begin
                pix_cnt     <= '0;
                overflow    <= 1'b0;
                short_frame <= 1'b0;
                word_cnt    <= '0;
            end else begin
                if (cap) pix_cnt <= pix_cnt + 20'd1;
                if (cap && fifo_full && !vif.wr_en) overflow <= 1'b1;
                if (short_set) short_frame <= 1'b1;
                if (vif.data_en) word_cnt <= word_cnt + 20'd1;
            end
        end
    end

    vga_capture_fifo #(.AW(FIFO_AW), .DW(PIX_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (cap),
        .wr_data  (s1_pix),
        .rd_req   (vif.wr_en),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_valid (vif.data_en),
        .rd_data  (vif.dout)
    );

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_q, crc_nx;

    assign crc_nx = vif.data_en ? crc16_step(crc_q, vif.dout) : crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q     <= CRC_INIT;
            frame_crc <= '0;
        end else if (arm) begin
            crc_q     <= CRC_INIT;
            frame_crc <= '0;
        end else begin
            crc_q <= crc_nx;
            if (done_nx) frame_crc <= crc_nx;
        end
    end
`else
    assign frame_crc = '0;
`endif
endmodule
